// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
    localparam int MD_WIDTH = 32;
    localparam int MULDIV_LATENCY = MD_WIDTH + 2;
    localparam logic [MD_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } muldiv_op_e;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the execute stage and muldiv_unit.
interface muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_LENGTH = 3
);
    logic                     Start;
    logic                     Flush;
    logic [FUNCT3_LENGTH-1:0] Funct3;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     Busy;
    logic                     Done;
    logic [DATA_WIDTH-1:0]    MulDivResult;
    modport master (output Start, Flush, Funct3, SrcA, SrcB, input Busy, Done, MulDivResult);
    modport slave (input Start, Flush, Funct3, SrcA, SrcB, output Busy, Done, MulDivResult);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitude conversion on entry, sign correction and result select in FIX.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_WIDTH
) (
    input  muldiv_op_e              op_in,
    input  logic [DATA_WIDTH-1:0]   src_a,
    input  logic [DATA_WIDTH-1:0]   src_b,
    output logic [DATA_WIDTH-1:0]   mag_a,
    output logic [DATA_WIDTH-1:0]   mag_b,
    output logic                    neg_a,
    output logic                    neg_b,
    input  muldiv_op_e              op,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   rem,
    input  logic                    sgn_a,
    input  logic                    sgn_b,
    input  logic                    dz,
    input  logic                    ovf,
    output logic [DATA_WIDTH-1:0]   result
);
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   quo;
    logic [DATA_WIDTH-1:0]   rmd;

    always_comb begin
        neg_a  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src_a[DATA_WIDTH-1];
        neg_b  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && src_b[DATA_WIDTH-1];
        mag_a  = neg_a ? -src_a : src_a;
        mag_b  = neg_b ? -src_b : src_b;
        prod   = (sgn_a ^ sgn_b) ? -acc : acc;
        quo    = (sgn_a ^ sgn_b) ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
        rmd    = sgn_a ? -rem : rem;
        // divide-by-zero remainder falls out naturally as SrcA; only the quotient is forced
        result = op == OP_MUL ? prod[DATA_WIDTH-1:0] :
                 !op[2] ? prod[2*DATA_WIDTH-1:DATA_WIDTH] :
                 (op == OP_DIV || op == OP_DIVU) ? (dz ? ALL_ONES : ovf ? INT_MIN : quo) :
                 ovf ? '0 : rmd;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply (shift-add) / divide (restoring), DATA_WIDTH+2 cycle latency.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete straight from Start.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = MD_WIDTH,
    parameter int FUNCT3_LENGTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    muldiv_state_e           state;
    muldiv_op_e              op, op_in;
    logic [FUNCT3_LENGTH-1:0] f3;
    logic [CW-1:0]           cnt;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]   rem, opb, mag_a, mag_b, fix_res, fast_res, result;
    logic [DATA_WIDTH:0]     sum, shifted;
    logic neg_a, neg_b, neg_a_q, neg_b_q, dz, ovf, dz_in, ovf_in, fast, take, busy, done;

    assign f3      = bus.Funct3;
    assign op_in   = muldiv_op_e'(f3);
    assign dz_in   = op_in[2] && bus.SrcB == '0;
    assign ovf_in  = (op_in == OP_DIV || op_in == OP_REM) && bus.SrcA == INT_MIN && bus.SrcB == ALL_ONES;
    assign sum     = acc[0] ? {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, opb}
                            : {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign shifted = {rem, acc[DATA_WIDTH-1]};
    assign take    = shifted >= {1'b0, opb};

`ifdef MULDIV_FAST_SPECIAL_EN
    assign fast     = dz_in || ovf_in;
    assign fast_res = ovf_in ? (op_in == OP_DIV ? INT_MIN : '0) :
                      (op_in == OP_DIV || op_in == OP_DIVU) ? ALL_ONES : bus.SrcA;
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
        .op_in(op_in), .src_a(bus.SrcA), .src_b(bus.SrcB),
        .mag_a(mag_a), .mag_b(mag_b), .neg_a(neg_a), .neg_b(neg_b),
        .op(op), .acc(acc), .rem(rem), .sgn_a(neg_a_q), .sgn_b(neg_b_q),
        .dz(dz), .ovf(ovf), .result(fix_res)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opb     <= '0;
            op      <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else if (bus.Flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (bus.Start && (state == IDLE || state == DONE)) begin
            state   <= fast ? DONE : CALC;
            busy    <= !fast;
            done    <= fast;
            op      <= op_in;
            cnt     <= '0;
            acc     <= {{DATA_WIDTH{1'b0}}, mag_a};
            rem     <= '0;
            opb     <= mag_b;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            dz      <= dz_in;
            ovf     <= ovf_in;
            if (fast) result <= fast_res;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            // divide reuses the low half of acc as dividend-in / quotient-out shift register
            if (op[2]) begin
                rem                 <= DATA_WIDTH'(take ? shifted - {1'b0, opb} : shifted);
                acc[DATA_WIDTH-1:0] <= {acc[DATA_WIDTH-2:0], take};
            end else
                acc <= {sum, acc[DATA_WIDTH-1:1]};
            if (cnt == CW'(DATA_WIDTH - 1)) state <= FIX;
        end else if (state == FIX) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fix_res;
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end

    assign bus.Busy         = busy;
    assign bus.Done         = done;
    assign bus.MulDivResult = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors checked against an arithmetic reference model every cycle.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    muldiv_if #(.DATA_WIDTH(32), .FUNCT3_LENGTH(3)) bus ();
    muldiv_unit #(.DATA_WIDTH(32), .FUNCT3_LENGTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub;
        logic        ov;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
        case (f)
            3'd0: return 32'(ua * ub);
            3'd1: return 32'((sa * sb) >> 32);
            3'd2: return 32'((sa * ub) >> 32);
            3'd3: return 32'((ua * ub) >> 32);
            3'd4: return b == 0 ? 32'hFFFFFFFF : ov ? a : 32'($signed(a) / $signed(b));
            3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
            3'd6: return b == 0 ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
`ifdef MULDIV_FAST_SPECIAL_EN
        return special ? 1 : MULDIV_LATENCY;
`else
        return special ? MULDIV_LATENCY : MULDIV_LATENCY;
`endif
    endfunction

    // Reference: an accepted op produces Done lat edges later; m_cnt counts cycles left until Done.
    logic        m_act;
    int          m_cnt;
    logic [31:0] m_res, m_pend;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (bus.Flush)
            m_act <= 1'b0;
        else if (bus.Start && (!m_act || m_cnt == 0)) begin
            m_act  <= 1'b1;
            m_cnt  <= lat(bus.Funct3, bus.SrcA, bus.SrcB) - 1;
            m_pend <= model(bus.Funct3, bus.SrcA, bus.SrcB);
            if (lat(bus.Funct3, bus.SrcA, bus.SrcB) == 1) m_res <= model(bus.Funct3, bus.SrcA, bus.SrcB);
        end else if (m_act && m_cnt == 0)
            m_act <= 1'b0;
        else if (m_act) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_res <= m_pend;
        end

    always @(negedge clk) begin
        chk("busy", 32'(bus.Busy), 32'(m_act && m_cnt != 0));
        chk("done", 32'(bus.Done), 32'(m_act && m_cnt == 0));
        chk("result", bus.MulDivResult, m_res);
        chk("busy_done_excl", 32'(bus.Busy && bus.Done), 32'd0);
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.Funct3 = f;
        bus.SrcA = a;
        bus.SrcB = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        issue(f, a, b);
        wait_done(n);
        chk({name, "_lat"}, 32'(n), 32'(lat(f, a, b)));
        chk(name, bus.MulDivResult, exp);
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] prev;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.Funct3 = '0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_result", bus.MulDivResult, 32'd0);
        #2 rst_n = 1'b1;

        run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        run_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_op("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);
        run_op("div_neg_by0", 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        // Flush ten cycles in: no Done, result held
        prev = bus.MulDivResult;
        issue(3'd5, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        chk("flush_busy", 32'(bus.Busy), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done) pulses++;
        end
        chk("flush_no_done", 32'(pulses), 32'd0);
        chk("flush_result", bus.MulDivResult, prev);

        // Start and Flush together while idle
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.Funct3 = 3'd0;
        bus.SrcA = 32'd3;
        bus.SrcB = 32'd3;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        chk("start_flush_busy", 32'(bus.Busy), 32'd0);
        @(negedge clk);
        chk("start_flush_done", 32'(bus.Done), 32'd0);

        // Back-to-back: Start held during the DONE cycle
        issue(3'd5, 32'd100, 32'd7);
        wait_done(n);
        chk("b2b_first", bus.MulDivResult, 32'd14);
        bus.Start = 1'b1;
        bus.Funct3 = 3'd7;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        chk("b2b_busy", 32'(bus.Busy), 32'd1);
        wait_done(n);
        chk("b2b_lat", 32'(n), 32'(MULDIV_LATENCY));
        chk("b2b_second", bus.MulDivResult, 32'd2);

        // Start while busy is ignored
        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        repeat (5) @(posedge clk);
        #1;
        bus.Start = 1'b1;
        bus.Funct3 = 3'd5;
        bus.SrcA = 32'd1;
        bus.SrcB = 32'd1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        wait_done(n);
        chk("ignore_lat", 32'(n), 32'(MULDIV_LATENCY - 6));
        chk("ignore_result", bus.MulDivResult, 32'hFFFFFFEB);

        // Asynchronous reset mid-CALC
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.Busy), 32'd0);
        chk("arst_done", 32'(bus.Done), 32'd0);
        chk("arst_result", bus.MulDivResult, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_op("after_rst", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
        run_op("after_rst_mul", 3'd0, 32'h00010001, 32'h00010001, 32'h00020001);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the RV32M extension, placed in the execute stage beside `alu`. It is fed by the same SrcA/SrcB operand muxes. Its result enters the same EX-stage result mux that consumes ALUResult. While an operation is in flight, Busy stalls the front of the pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width.
- FUNCT3_LENGTH, 3, width of the operation select.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- Start, input, 1, request to begin an operation.
- Flush, input, 1, synchronous kill of the in-flight operation.
- Funct3, input, FUNCT3_LENGTH, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA, input, DATA_WIDTH, rs1 operand (multiplicand or dividend).
- SrcB, input, DATA_WIDTH, rs2 operand (multiplier or divisor).
- Busy, output, 1, operation in progress; the pipeline stalls on it.
- Done, output, 1, one-cycle pulse; the result is valid in this cycle.
- MulDivResult, output, DATA_WIDTH, registered result.

## Operation
- FSM states and transitions:
  - IDLE -> CALC when Start is high.
  - CALC runs for DATA_WIDTH cycles, with iteration counter 0..DATA_WIDTH-1, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE, or -> CALC if Start is high.
- Output decode:
  - Busy = (state == CALC or FIX).
  - Done = (state == DONE).
- Operand capture on an accepted Start:
  - Capture Funct3.
  - Convert operands to magnitudes per signedness: signed for MULH, DIV and REM; SrcA only for MULHSU; unsigned for MULHU, DIVU and REMU.
  - Record the result sign.
- Multiply datapath:
  - Shift-add, one bit per CALC cycle, into a 2*DATA_WIDTH accumulator.
- Divide datapath:
  - Restoring division, one quotient bit per CALC cycle.
  - Partial remainder is DATA_WIDTH+1 bits.
- FIX cycle (sign correction):
  - Two's-complement negate where required.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Select low or high half, quotient or remainder.
  - Register the result into MulDivResult.
- Special cases (results are RISC-V compliant):
  - Divide by zero: DIV/DIVU return all ones. REM/REMU return SrcA.
  - Signed overflow, SrcA = 0x80000000 with SrcB = 0xFFFFFFFF: DIV returns 0x80000000. REM returns 0.
- Start outside IDLE or DONE is ignored. The upstream logic holds the instruction in place via Busy.
- Flush:
  - From any state, the next state is IDLE and no Done is produced.
  - MulDivResult keeps its previous value.
  - Flush wins over a simultaneous Start.
- MulDivResult holds the last result until the next FIX or fast-path completion.
- Reset: state IDLE, Busy 0, Done 0, MulDivResult 0, counter and accumulators 0.
- Reset asserted mid-operation aborts it immediately (asynchronously), with no Done.

## Timing
- Start is sampled at edge t:
  - Busy is high from t+1 through the edge at t+DATA_WIDTH+1.
  - Done is high for exactly one cycle after edge t+DATA_WIDTH+2.
  - Latency is DATA_WIDTH+2 cycles (34 at the default width).
- Back-to-back: Start during the DONE cycle is accepted. There is no idle bubble, and Busy rises the next cycle.
- Busy and Done are never high in the same cycle.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- MULDIV_FAST_SPECIAL_EN defined:
  - Divide-by-zero and signed overflow are detected on an accepted Start.
  - The FSM goes directly to DONE, so Done is high in the cycle after edge t+1.
  - Busy is never asserted for these cases.
- Macro undefined:
  - Special cases run the full DATA_WIDTH+2 latency.
  - Results are identical. Special-case results are forced in FIX.

## Structure
- Package `muldiv_pkg` contains:
  - The Funct3 operation enum (`muldiv_op_e`).
  - The FSM state enum (IDLE, CALC, FIX, DONE).
  - The constant MULDIV_LATENCY = DATA_WIDTH+2.
  - The special-case constants: all-ones, and INT_MIN.
- One natural sub-module, `muldiv_sign_fix`, is purely combinational. It handles magnitude conversion on entry and conditional negate and select in FIX.
- The iteration datapath and FSM stay in `muldiv_unit`.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD (−3) -> MulDivResult 0xFFFFFFEB with Done exactly 34 cycles after Start. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
  - Latency is 1 cycle with MULDIV_FAST_SPECIAL_EN, 34 cycles without it.
- Flush asserted 10 cycles after Start -> Busy low in the next cycle, no Done, MulDivResult unchanged. Simultaneous Start+Flush in IDLE -> stays IDLE.
- Back-to-back and reset:
  - Start held during DONE -> second operation accepted with no idle cycle. Start pulsed while Busy -> ignored.
  - rst_n dropped mid-CALC -> all outputs 0 immediately. Next Start after release completes normally.
